// File: rtl/afisaj_pkg.sv
// Shared constants for the counter display: converter states, segment table, digit slots.
// Latency: n/a (package). Backpressure: none.
package afisaj_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a}; entry i is the pattern for decimal digit i.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    localparam logic [1:0] DIG_UNITS    = 2'd0;
    localparam logic [1:0] DIG_TENS     = 2'd1;
    localparam logic [1:0] DIG_HUNDREDS = 2'd2;
    localparam logic [1:0] DIG_OFF      = 2'd3;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        if (d > 4'd9)
            return SEG_BLANK;
        return SEG_TABLE[d];
    endfunction

    // One double-dabble step: correct every BCD nibble, then shift the whole register.
    function automatic logic [19:0] add3_shift(input logic [19:0] r);
        logic [19:0] t;
        t = r;
        for (int k = 0; k < 3; k++) begin
            if (t[8+4*k +: 4] >= 4'd5)
                t[8+4*k +: 4] = t[8+4*k +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/afisaj_7seg_if.sv
// Counter value in, BCD result and multiplexed display pins out.
// Latency: n/a (interface). Backpressure: none, all signals free-running.
interface afisaj_7seg_if;
    logic [7:0]  q_in;
    logic [11:0] bcd;
    logic        conv_done;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (output q_in, input bcd, conv_done, an, seg, dp);
    modport slave  (input q_in, output bcd, conv_done, an, seg, dp);
endinterface

// File: rtl/afisaj_7seg_bin2bcd8.sv
// Sequential 8-bit binary to 3-digit BCD converter, restarting every pass.
// Latency: 10 cycles sample-to-bcd, one pass per 10 cycles. Backpressure: none.
module bin2bcd8
    import afisaj_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  q_in,
    output logic [11:0] bcd,
    output logic        conv_done
);

    conv_state_t state, state_nxt;
    logic [19:0] sr, sr_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [11:0] bcd_nxt;
    logic        done_nxt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            sr        <= '0;
            cnt       <= '0;
            bcd       <= '0;
            conv_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            sr        <= sr_nxt;
            cnt       <= cnt_nxt;
            bcd       <= bcd_nxt;
            conv_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
        bcd_nxt   = bcd;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                sr_nxt    = {12'd0, q_in};
                cnt_nxt   = 3'd0;
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                sr_nxt  = add3_shift(sr);
                cnt_nxt = cnt + 3'd1;
                if (cnt == 3'd7)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                bcd_nxt   = sr[19:8];
                done_nxt  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/afisaj_7seg.sv
// Converts counter values to BCD and scans them onto a 4-digit common-anode display.
// Latency: bcd 10 cycles after sample, pins 1 cycle after digit change. Backpressure: none.
module afisaj_7seg
    import afisaj_pkg::*;
#(
    parameter int DIGIT_PERIOD = 50000
) (
    input  logic           CLK,
    input  logic           RST,
    afisaj_7seg_if.slave   io
);

    localparam int RW = $clog2(DIGIT_PERIOD);

    logic [11:0]   bcd_w;
    logic          done_w;
    logic [RW-1:0] rcnt;
    logic [1:0]    dig;
    logic [3:0]    an_r;
    logic [6:0]    seg_r, seg_nxt;

    bin2bcd8 u_conv (
        .CLK       (CLK),
        .RST       (RST),
        .q_in      (io.q_in),
        .bcd       (bcd_w),
        .conv_done (done_w)
    );

    // Leading zeros are blanked; units always shows, slot 3 is never lit with a digit.
    always_comb begin
        seg_nxt = SEG_BLANK;
        case (dig)
            DIG_UNITS:    seg_nxt = seg_of(bcd_w[3:0]);
            DIG_TENS:     if (bcd_w[11:4] != 8'd0) seg_nxt = seg_of(bcd_w[7:4]);
            DIG_HUNDREDS: if (bcd_w[11:8] != 4'd0) seg_nxt = seg_of(bcd_w[11:8]);
            default:      seg_nxt = SEG_BLANK;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rcnt  <= '0;
            dig   <= DIG_UNITS;
            an_r  <= 4'b1110;
            seg_r <= SEG_TABLE[0];
        end else begin
            if (rcnt == RW'(DIGIT_PERIOD - 1)) begin
                rcnt <= '0;
                dig  <= dig + 2'd1;
            end else begin
                rcnt <= rcnt + RW'(1);
            end
            an_r  <= ~(4'b0001 << dig);
            seg_r <= seg_nxt;
        end
    end

    assign io.bcd       = bcd_w;
    assign io.conv_done = done_w;
    assign io.an        = an_r;
    assign io.seg       = seg_r;
    assign io.dp        = 1'b1;

endmodule

// File: tb/tb_afisaj_7seg.sv
// Scoreboard bench: stimulus queues expected conversions, a negedge monitor checks them and the display.
module tb_afisaj_7seg;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        int due;
        int val;
    } exp_t;
    exp_t sbq[$];

    logic [6:0] codes [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    afisaj_7seg_if io();

    afisaj_7seg #(.DIGIT_PERIOD(DP)) dut (
        .CLK (clk),
        .RST (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    // Edges since the last reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    function automatic int to_bcd(input int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    function automatic logic [6:0] seg_ref(input int idx, input int val);
        case (idx)
            0:       return codes[val % 10];
            1:       return (val >= 10)  ? codes[(val / 10) % 10] : 7'b1111111;
            2:       return (val >= 100) ? codes[val / 100]       : 7'b1111111;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%0h expected=%0h t=%0t", name, n, act, expv, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_an"},   int'(io.an),        'h e);
        check({tag, "_seg"},  int'(io.seg),       'h 40);
        check({tag, "_dp"},   int'(io.dp),        1);
        check({tag, "_bcd"},  int'(io.bcd),       0);
        check({tag, "_done"}, int'(io.conv_done), 0);
    endtask

    // Monitor: model state is the display index and value as they stood after the previous edge.
    int cur_idx = 0;
    int cur_val = 0;
    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] an_exp;
        if (rst || n == 0) begin
            check_reset_vals("rst");
            cur_idx = 0;
            cur_val = 0;
        end else begin
            an_exp = 4'b1111;
            an_exp[cur_idx] = 1'b0;
            check("an",  int'(io.an),  int'(an_exp));
            check("seg", int'(io.seg), int'(seg_ref(cur_idx, cur_val)));
            check("dp",  int'(io.dp),  1);
            if (sbq.size() > 0 && sbq[0].due == n) begin
                e = sbq.pop_front();
                check("conv_done_pulse", int'(io.conv_done), 1);
                check("bcd_result", int'(io.bcd), to_bcd(e.val));
                cur_val = e.val;
            end else begin
                check("conv_done_idle", int'(io.conv_done), 0);
                check("bcd_hold", int'(io.bcd), to_bcd(cur_val));
            end
            cur_idx = (n / DP) % 4;
        end
    end

    task automatic apply_reset(input int hold, input logic [7:0] v);
        @(posedge clk);
        #2;
        io.q_in = 8'd200;
        rst = 1'b1;
        sbq.delete();
        #1;
        check_reset_vals("rst_immediate");
        repeat (hold) @(posedge clk);
        #2;
        io.q_in = v;
        rst = 1'b0;
        sbq.push_back('{10, int'(v)});
    endtask

    // mode 0: hold q_in, 1: increment each cycle, 2: random each cycle.
    task automatic run_cycles(input int cycles, input int mode);
        repeat (cycles) begin
            @(posedge clk);
            #2;
            case (mode)
                1:       io.q_in = io.q_in + 8'd1;
                2:       io.q_in = 8'($urandom_range(0, 255));
                default: ;
            endcase
            if ((n + 1) % 10 == 1)
                sbq.push_back('{n + 10, int'(io.q_in)});
        end
    endtask

    initial begin
        io.q_in = 8'd200;
        #1;
        rst = 1'b1;
        #1;
        check_reset_vals("rst_assert");
        apply_reset(4, 8'd255);
        run_cycles(45, 0);
        apply_reset(2, 8'd7);
        run_cycles(40, 0);
        apply_reset(2, 8'd100);
        run_cycles(50, 0);
        apply_reset(2, 8'd150);
        run_cycles(1000, 1);
        apply_reset(2, 8'd33);
        run_cycles(4, 0);
        apply_reset(3, 8'd42);
        run_cycles(30, 0);
        apply_reset(2, 8'd0);
        run_cycles(300, 2);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
